// File: rtl/dec_3to8_reg.sv
// dec_3to8_reg: clocked 3-to-8 one-hot decoder with optional output register, enable, polarity and change flag
module dec_3to8_reg #(
    parameter bit REG_OUT        = 1'b1,
    parameter bit ACTIVE_LOW_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       changed
);
    localparam logic [7:0] IDLE = ACTIVE_LOW_OUT ? 8'hFF : 8'h00;
    logic [7:0] one_hot;
    logic [7:0] dec;
    logic [2:0] last_a;
    logic       last_ok;
    always_comb begin
        one_hot = 8'h01 << a;
        dec     = en ? (ACTIVE_LOW_OUT ? ~one_hot : one_hot) : IDLE;
    end
    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y       <= IDLE;
                    y_valid <= 1'b0;
                end else begin
                    y       <= dec;
                    y_valid <= en;
                end
            end
        end else begin : g_comb
            assign y       = dec;
            assign y_valid = en;
        end
    endgenerate
    // last_ok drops on disabled cycles so the next enabled code always pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            last_ok <= 1'b0;
            last_a  <= 3'd0;
        end else begin
            changed <= en && (!last_ok || a != last_a);
            last_ok <= en;
            if (en) last_a <= a;
        end
    end
endmodule

// File: tb/tb_dec_3to8_reg.sv
// tb_dec_3to8_reg: table-driven check of registered, active-low and combinational decoder builds
module tb_dec_3to8_reg;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] a;
    logic [7:0] y_r, y_l, y_c;
    logic       v_r, v_l, v_c;
    logic       c_r, c_l, c_c;
    int         errs;
    int         checks;
    typedef struct {
        logic       en;
        logic [2:0] a;
        logic [7:0] y;
        logic       v;
        logic       c;
    } vec_t;
    vec_t vecs[$];
    logic [7:0] sweep_y[9];
    dec_3to8_reg #(.REG_OUT(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .y(y_r), .y_valid(v_r), .changed(c_r));
    dec_3to8_reg #(.REG_OUT(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_low (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .y(y_l), .y_valid(v_l), .changed(c_l));
    dec_3to8_reg #(.REG_OUT(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .y(y_c), .y_valid(v_c), .changed(c_c));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic add(input logic e, input logic [2:0] av, input logic [7:0] yv, input logic vv, input logic cv);
        vec_t t;
        t.en = e; t.a = av; t.y = yv; t.v = vv; t.c = cv;
        vecs.push_back(t);
    endtask
    initial begin
        errs = 0;
        checks = 0;
        sweep_y = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        for (int i = 0; i < 9; i++) begin
            add(1'b1, 3'(i % 8), sweep_y[i], 1'b1, 1'b1);
            add(1'b1, 3'(i % 8), sweep_y[i], 1'b1, 1'b0);
        end
        add(1'b1, 3'd5, 8'h20, 1'b1, 1'b1);
        add(1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
        add(1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
        add(1'b1, 3'd5, 8'h20, 1'b1, 1'b1);
        add(1'b1, 3'd5, 8'h20, 1'b1, 1'b0);
        add(1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        add(1'b1, 3'd6, 8'h40, 1'b1, 1'b1);
        add(1'b0, 3'bxxx, 8'h00, 1'b0, 1'b0);
        add(1'b1, 3'd2, 8'h04, 1'b1, 1'b1);
        add(1'b1, 3'd2, 8'h04, 1'b1, 1'b0);
        rst_n = 1'b0;
        en = 1'b1;
        a = 3'd3;
        tick();
        tick();
        chk("rst_y", y_r, 8'h00);
        chk("rst_valid", v_r, 1'b0);
        chk("rst_changed", c_r, 1'b0);
        chk("rst_y_low", y_l, 8'hFF);
        chk("rst_changed_comb", c_c, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("first_y", y_r, 8'h08);
        chk("first_valid", v_r, 1'b1);
        chk("first_changed", c_r, 1'b1);
        chk("first_y_low", y_l, 8'hF7);
        foreach (vecs[i]) begin
            en = vecs[i].en;
            a = vecs[i].a;
            #2;
            chk($sformatf("comb_y[%0d]", i), y_c, vecs[i].y);
            chk($sformatf("comb_valid[%0d]", i), v_c, vecs[i].v);
            tick();
            chk($sformatf("y[%0d]", i), y_r, vecs[i].y);
            chk($sformatf("valid[%0d]", i), v_r, vecs[i].v);
            chk($sformatf("changed[%0d]", i), c_r, vecs[i].c);
            chk($sformatf("onehot[%0d]", i), 8'($countones(y_r)), 8'(vecs[i].v));
            chk($sformatf("y_low[%0d]", i), y_l, ~vecs[i].y);
            chk($sformatf("changed_low[%0d]", i), c_l, vecs[i].c);
            chk($sformatf("changed_comb[%0d]", i), c_c, vecs[i].c);
        end
        en = 1'b1;
        a = 3'd7;
        tick();
        chk("pre_async_y", y_r, 8'h80);
        chk("pre_async_changed", c_r, 1'b1);
        a = 3'd1;
        #2;
        chk("hold_between_edges", y_r, 8'h80);
        chk("comb_between_edges", y_c, 8'h02);
        a = 3'd7;
        #1 rst_n = 1'b0;
        #1;
        chk("async_y", y_r, 8'h00);
        chk("async_valid", v_r, 1'b0);
        chk("async_changed", c_r, 1'b0);
        chk("async_y_low", y_l, 8'hFF);
        #1 rst_n = 1'b1;
        tick();
        chk("post_async_y", y_r, 8'h80);
        chk("post_async_changed", c_r, 1'b1);
        tick();
        chk("post_async_hold", c_r, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dec_3to8_reg.md
Name: dec_3to8_reg

Overview:
- Clocked 3-to-8 one-hot decoder: a 3-bit binary code on `a` drives exactly one active bit on `y`, at index `a`.
- Optional output register, enable gating, selectable output polarity, plus valid and code-change flags.
- Used as an address/select decoder feeding chip-select or row-select lines in downstream datapaths.

Parameters:
- REG_OUT, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs combinational from `a`/`en`, and clock/reset affect only `changed`.
- ACTIVE_LOW_OUT, default 0: 0 = selected bit is 1, others 0; 1 = selected bit is 0, others 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  decode enable; 0 forces `y` to the all-inactive pattern
- a  input  3  binary code to decode, 0..7
- y  output  8  one-hot decoded select, polarity per ACTIVE_LOW_OUT
- y_valid  output  1  1 when `y` holds a decoded (enabled) code
- changed  output  1  single-cycle pulse when the decoded code differs from the previously decoded code

Behaviour:
- Decode function, active-high form:
  - en=1: y[i] = (a == i) for i = 0..7; y_valid = 1.
  - en=0: y = 8'h00; y_valid = 0.
  - ACTIVE_LOW_OUT=1: y is the bitwise inverse (all-inactive = 8'hFF). y_valid and changed are never inverted.
- Mapping, active-high: a=0 -> 8'h01, 1 -> 8'h02, 2 -> 8'h04, 3 -> 8'h08, 4 -> 8'h10, 5 -> 8'h20, 6 -> 8'h40, 7 -> 8'h80.
- Invariant: while y_valid=1, exactly one bit of y is active. While y_valid=0, no bit is active.
- REG_OUT=1:
  - y and y_valid are registered; the output at edge N reflects a/en sampled at edge N.
  - Latency is exactly 1 clock.
  - Input changes between edges have no effect on outputs.
- REG_OUT=0: y and y_valid follow a/en combinationally, with zero latency.
- Reset:
  - rst_n low immediately (asynchronously) forces y to all-inactive (8'h00, or 8'hFF when active-low), y_valid = 0, changed = 0, and clears the last-code register.
  - Deassertion is sampled synchronously; the first decode occurs at the first rising edge with rst_n high.
  - Reset asserted mid-stream discards the in-flight code; no `changed` pulse is produced by reset itself.
- `changed` (registered in both REG_OUT modes):
  - Asserted for one cycle at the edge where en=1 and the sampled a differs from the last enabled code.
  - Also asserted on the first enabled code after reset or after a period with en=0.
  - Held or repeated codes produce no pulse. en=0 cycles produce no pulse and do not update the last code.
- Wrap-around: a going 7 -> 0 is an ordinary code change (y 8'h80 -> 8'h01, changed pulses). No overflow state exists.
- Simultaneous en falling and a changing: en dominates; y goes inactive and changed stays 0.
- X/Z on `a` while en=1: output is don't-care. X/Z on `a` while en=0 must not affect y (y stays all-inactive).

Test Plan:
- Reset: hold rst_n=0 with a=3, en=1 -> y=8'h00, y_valid=0, changed=0. Release, then one edge later -> y=8'h08, y_valid=1, changed=1.
- Sweep with REG_OUT=1: from a=0, increment a every 2 clocks through 7 and wrap to 0, en=1.
  - y steps 01,02,04,08,10,20,40,80,01, each one cycle after the a change.
  - changed pulses once per step, including the 7 -> 0 wrap.
  - Check the one-hot invariant every cycle.
- Enable gating: a=5, toggle en 1 -> 0 -> 1.
  - en=0: y=8'h00 and y_valid=0 on the next edge.
  - en back to 1: y=8'h20 and changed=1, even though a is unchanged.
- Active-low build (ACTIVE_LOW_OUT=1): a=2, en=1 -> y=8'hFB. en=0 -> y=8'hFF. Reset -> y=8'hFF.
- Combinational build (REG_OUT=0): a=6 applied mid-cycle -> y=8'h40 within the same cycle, with no clock edge required.
- Async reset mid-operation: with a=7 and y=8'h80, pulse rst_n low between edges -> y=8'h00 immediately, before the next edge. After release, a=7 decodes again with changed=1.
